// File: rtl/lsu_pkg.sv
// Shared load/store definitions: FSM states, is_LS field layout, size codes,
// and the offset/alignment helpers used by lsu_ctrl and lsu_align.
package lsu_pkg;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_ERR} lsu_state_e;

   localparam int LS_EN     = 3;
   localparam int LS_ST     = 2;
   localparam int LS_SZ_HI  = 1;
   localparam int LS_SZ_LO  = 0;
   localparam int NUM_LANES = 4;

   localparam logic [1:0] SZ_W = 2'b11;
   localparam logic [1:0] SZ_H = 2'b10;
   localparam logic [1:0] SZ_B = 2'b01;

   // Operation captured at accept; held for the life of the bus access.
   typedef struct packed {
      logic       st;
      logic       sign;
      logic [1:0] sz;
      logic [1:0] off;
      logic [4:0] rd;
   } ls_op_t;

   // Byte offset actually used on the bus: half/word snap to natural alignment.
   function automatic logic [1:0] eff_off(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         SZ_W:    return 2'b00;
         SZ_H:    return {a[1], 1'b0};
         default: return a;
      endcase
   endfunction

   function automatic logic is_misalign(input logic [1:0] sz, input logic [1:0] a);
      return ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory req/gnt/rvalid bus; master is the LSU, slave is memory.
interface lsu_ctrl_if #(parameter int ADDR_W = 32) ();
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   input  mem_gnt, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extract/extend for loads; purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  st_sz,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [1:0]  ld_sz,
   input  logic [1:0]  ld_off,
   input  logic        ld_sign,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [NUM_LANES-1:0][7:0] lane_w;
   logic [31:0]               r;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LN = 2'(i);
      assign st_be[i]  = (st_sz == SZ_W) |
                         ((st_sz == SZ_H) ? (st_off[1] == LN[1]) : (st_off == LN));
      assign lane_w[i] = (st_sz == SZ_W) ? st_data[8*i +: 8] :
                         (st_sz == SZ_H) ? st_data[8*(i%2) +: 8] : st_data[7:0];
   end
   assign st_wdata = lane_w;

   assign r = ld_rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data = r;
      case (ld_sz)
         SZ_W:    ld_data = r;
         SZ_H:    ld_data = {{16{ld_sign & r[15]}}, r[15:0]};
         default: ld_data = {{24{ld_sign & r[7]}}, r[7:0]};
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: single-outstanding bus FSM, capture regs and timeout.
// LSU_MISALIGN_TRAP_EN: misaligned half/word accesses trap via ERR instead of issuing.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int TO_CYCLES = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              ls_vld,
   input  logic [3:0]        ls_ctrl,
   input  logic              ls_sign,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   input  logic [4:0]        ls_rd,
   input  logic              ls_flush,
   output logic              lsu_busy,
   lsu_ctrl_if.master        mem,
   output logic              wb_vld,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              st_done,
   output logic              bus_err,
   output logic              lsu_misalign
);

   lsu_state_e  state, state_nxt;
   ls_op_t      op;
   logic [15:0] to_cnt;
   logic        acc, to_hit, trap;
   logic        st_done_nxt, wb_nxt, err_nxt;
   logic [1:0]  in_sz, in_off;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;

   assign in_sz    = ls_ctrl[LS_SZ_HI:LS_SZ_LO];
   assign in_off   = eff_off(in_sz, ls_addr[1:0]);
   assign acc      = ls_vld & ls_ctrl[LS_EN] & ~ls_flush & (state == S_IDLE);
   assign lsu_busy = acc | (state != S_IDLE);
   assign to_hit   = (to_cnt == 16'(TO_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = is_misalign(in_sz, ls_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   lsu_align u_align (
      .st_sz    (in_sz),
      .st_off   (in_off),
      .st_data  (ls_wdata),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .ld_sz    (op.sz),
      .ld_off   (op.off),
      .ld_sign  (op.sign),
      .ld_rdata (mem.mem_rdata),
      .ld_data  (ld_data)
   );

   // Awaited gnt/rvalid is checked before the timeout so a last-cycle response wins.
   always_comb begin
      state_nxt   = state;
      st_done_nxt = 1'b0;
      wb_nxt      = 1'b0;
      err_nxt     = 1'b0;
      case (state)
         S_IDLE: if (acc) state_nxt = trap ? S_ERR : S_REQ;
         S_REQ: begin
            if (mem.mem_gnt) begin
               state_nxt   = op.st ? S_IDLE : S_WAIT;
               st_done_nxt = op.st;
            end else if (to_hit) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         S_WAIT: begin
            if (mem.mem_rvalid) begin
               state_nxt = S_IDLE;
               wb_nxt    = 1'b1;
            end else if (to_hit) begin
               state_nxt = S_IDLE;
               err_nxt   = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= S_IDLE;
         op            <= '0;
         to_cnt        <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
         wb_vld        <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         st_done       <= 1'b0;
         bus_err       <= 1'b0;
         lsu_misalign  <= 1'b0;
      end else begin
         state       <= state_nxt;
         mem.mem_req <= (state_nxt == S_REQ);
         st_done     <= st_done_nxt;
         wb_vld      <= wb_nxt;
         bus_err     <= err_nxt;
`ifdef LSU_MISALIGN_TRAP_EN
         lsu_misalign <= (state_nxt == S_ERR);
`else
         lsu_misalign <= 1'b0;
`endif
         if (acc)
            to_cnt <= '0;
         else if (state == S_REQ || state == S_WAIT)
            to_cnt <= to_cnt + 16'd1;
         if (acc) begin
            op            <= '{st: ls_ctrl[LS_ST], sign: ls_sign, sz: in_sz, off: in_off, rd: ls_rd};
            mem.mem_we    <= ls_ctrl[LS_ST];
            mem.mem_addr  <= {ls_addr[ADDR_W-1:2], 2'b00};
            mem.mem_be    <= st_be;
            mem.mem_wdata <= st_wdata;
         end
         if (state == S_WAIT && mem.mem_rvalid) begin
            wb_rd   <= op.rd;
            wb_data <= ld_data;
         end
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (TO_CYCLES=4): loads, stores, timeout, reset, flush, misalign.
module tb_lsu_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ls_vld, ls_sign, ls_flush;
   logic [3:0]  ls_ctrl;
   logic [31:0] ls_addr, ls_wdata;
   logic [4:0]  ls_rd;
   logic        lsu_busy, wb_vld, st_done, bus_err, lsu_misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   int          n_cmp = 0;
   int          n_err = 0;

   lsu_ctrl_if #(.ADDR_W(32)) mem_bus ();

   lsu_ctrl #(.ADDR_W(32), .TO_CYCLES(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .ls_vld       (ls_vld),
      .ls_ctrl      (ls_ctrl),
      .ls_sign      (ls_sign),
      .ls_addr      (ls_addr),
      .ls_wdata     (ls_wdata),
      .ls_rd        (ls_rd),
      .ls_flush     (ls_flush),
      .lsu_busy     (lsu_busy),
      .mem          (mem_bus),
      .wb_vld       (wb_vld),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .st_done      (st_done),
      .bus_err      (bus_err),
      .lsu_misalign (lsu_misalign)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      ls_vld = 0; ls_ctrl = 0; ls_sign = 0; ls_addr = 0;
      ls_wdata = 0; ls_rd = 0; ls_flush = 0;
   endtask

   task automatic present(input logic [3:0] ctrl, input logic sign, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
      ls_vld = 1; ls_ctrl = ctrl; ls_sign = sign; ls_addr = addr; ls_wdata = wdata; ls_rd = rd;
   endtask

   // Load granted in its first REQ cycle, rvalid in the first WAIT cycle.
   task automatic load_fast(input string tag, input logic [3:0] ctrl, input logic sign,
                            input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_data);
      present(ctrl, sign, addr, 32'h0, rd);
      mem_bus.mem_gnt = 1;
      tick(); idle_in();
      chk({tag, "_addr"}, mem_bus.mem_addr, exp_addr);
      chk({tag, "_be"}, {28'h0, mem_bus.mem_be}, {28'h0, exp_be});
      tick(); mem_bus.mem_gnt = 0;
      chk({tag, "_req_drop"}, {31'h0, mem_bus.mem_req}, 32'h0);
      mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = rdata;
      tick(); mem_bus.mem_rvalid = 0;
      chk({tag, "_wb_vld"}, {31'h0, wb_vld}, 32'h1);
      chk({tag, "_wb_rd"}, {27'h0, wb_rd}, {27'h0, rd});
      chk({tag, "_wb_data"}, wb_data, exp_data);
      tick();
      chk({tag, "_wb_pulse"}, {31'h0, wb_vld}, 32'h0);
   endtask

   initial begin
      idle_in();
      mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
      RST = 1;
      tick(); tick();
      chk("rst_req", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_busy", {31'h0, lsu_busy}, 32'h0);
      chk("rst_flags", {28'h0, wb_vld, st_done, bus_err, lsu_misalign}, 32'h0);
      RST = 0;
      tick();

      // LB signed @0x103, gnt on 2nd REQ cycle, rvalid 2 cycles after gnt
      present(4'b1001, 1'b1, 32'h103, 32'h0, 5'd5);
      #1 chk("lb_busy_acc", {31'h0, lsu_busy}, 32'h1);
      tick(); idle_in();
      chk("lb_req", {31'h0, mem_bus.mem_req}, 32'h1);
      chk("lb_addr", mem_bus.mem_addr, 32'h100);
      chk("lb_be", {28'h0, mem_bus.mem_be}, 32'h8);
      chk("lb_we", {31'h0, mem_bus.mem_we}, 32'h0);
      tick(); mem_bus.mem_gnt = 1;
      tick(); mem_bus.mem_gnt = 0;
      chk("lb_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("lb_busy_wait", {31'h0, lsu_busy}, 32'h1);
      tick();
      mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h8000_0000;
      tick(); mem_bus.mem_rvalid = 0;
      chk("lb_wb_vld", {31'h0, wb_vld}, 32'h1);
      chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
      chk("lb_wb_rd", {27'h0, wb_rd}, 32'd5);
      chk("lb_busy_fall", {31'h0, lsu_busy}, 32'h0);
      tick();
      chk("lb_wb_pulse", {31'h0, wb_vld}, 32'h0);

      // LHU / LH @0x202
      load_fast("lhu", 4'b1010, 1'b0, 32'h202, 5'd7, 32'hBEEF_1234, 32'h200, 4'b1100, 32'h0000_BEEF);
      load_fast("lh",  4'b1010, 1'b1, 32'h202, 5'd8, 32'hBEEF_1234, 32'h200, 4'b1100, 32'hFFFF_BEEF);

      // SB @0x001, gnt held low 3 cycles, granted on the final (timeout) cycle
      present(4'b1101, 1'b0, 32'h001, 32'h1234_56AB, 5'd0);
      tick(); idle_in();
      for (int i = 0; i < 4; i++) begin
         chk("sb_req", {31'h0, mem_bus.mem_req}, 32'h1);
         chk("sb_we", {31'h0, mem_bus.mem_we}, 32'h1);
         chk("sb_addr", mem_bus.mem_addr, 32'h0);
         chk("sb_be", {28'h0, mem_bus.mem_be}, 32'h2);
         chk("sb_wdata", mem_bus.mem_wdata, 32'hABAB_ABAB);
         if (i == 3) mem_bus.mem_gnt = 1;
         tick();
      end
      mem_bus.mem_gnt = 0;
      chk("sb_st_done", {31'h0, st_done}, 32'h1);
      chk("sb_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("sb_no_err", {31'h0, bus_err}, 32'h0);
      chk("sb_no_wb", {31'h0, wb_vld}, 32'h0);
      tick();
      chk("sb_st_pulse", {31'h0, st_done}, 32'h0);

      // SH @0x002 granted immediately
      present(4'b1110, 1'b0, 32'h002, 32'hAAAA_5678, 5'd0);
      mem_bus.mem_gnt = 1;
      tick(); idle_in();
      chk("sh_be", {28'h0, mem_bus.mem_be}, 32'hC);
      chk("sh_wdata", mem_bus.mem_wdata, 32'h5678_5678);
      tick(); mem_bus.mem_gnt = 0;
      chk("sh_st_done", {31'h0, st_done}, 32'h1);
      tick();

      // LW never granted -> bus_err after 4 REQ cycles
      present(4'b1011, 1'b0, 32'h40, 32'h0, 5'd3);
      tick(); idle_in();
      tick(); tick(); tick();
      chk("to_req_last", {31'h0, mem_bus.mem_req}, 32'h1);
      tick();
      chk("to_bus_err", {31'h0, bus_err}, 32'h1);
      chk("to_req_low", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("to_busy", {31'h0, lsu_busy}, 32'h0);
      chk("to_no_wb", {31'h0, wb_vld}, 32'h0);
      tick();
      chk("to_err_pulse", {31'h0, bus_err}, 32'h0);

      // Reset during WAIT; rvalid after reset must be ignored
      present(4'b1011, 1'b0, 32'h44, 32'h0, 5'd4);
      mem_bus.mem_gnt = 1;
      tick(); idle_in();
      tick(); mem_bus.mem_gnt = 0;
      RST = 1;
      tick(); RST = 0;
      mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h5555_AAAA;
      tick(); mem_bus.mem_rvalid = 0;
      chk("rstw_wb_vld", {31'h0, wb_vld}, 32'h0);
      chk("rstw_wb_data", wb_data, 32'h0);
      chk("rstw_wb_rd", {27'h0, wb_rd}, 32'h0);
      chk("rstw_bus", {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_be}, 6'h0);
      chk("rstw_addr", mem_bus.mem_addr, 32'h0);
      chk("rstw_wdata", mem_bus.mem_wdata, 32'h0);
      chk("rstw_flags", {29'h0, st_done, bus_err, lsu_busy}, 32'h0);

      // Flushed SW is ignored
      present(4'b1111, 1'b0, 32'h80, 32'h1, 5'd0);
      ls_flush = 1;
      #1 chk("fl_busy", {31'h0, lsu_busy}, 32'h0);
      tick(); idle_in();
      chk("fl_no_req", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("fl_idle", {31'h0, lsu_busy}, 32'h0);

      // Flush pulse during WAIT does not cancel the LW
      present(4'b1011, 1'b0, 32'h10, 32'h0, 5'd9);
      mem_bus.mem_gnt = 1;
      tick(); idle_in();
      tick(); mem_bus.mem_gnt = 0;
      ls_flush = 1;
      tick(); ls_flush = 0;
      mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'hCAFE_F00D;
      tick(); mem_bus.mem_rvalid = 0;
      chk("flw_wb_vld", {31'h0, wb_vld}, 32'h1);
      chk("flw_wb_data", wb_data, 32'hCAFE_F00D);
      tick();

      // Misaligned LW @0x006
`ifdef LSU_MISALIGN_TRAP_EN
      present(4'b1011, 1'b0, 32'h006, 32'h0, 5'd2);
      tick(); idle_in();
      chk("mis_flag", {31'h0, lsu_misalign}, 32'h1);
      chk("mis_no_req", {31'h0, mem_bus.mem_req}, 32'h0);
      chk("mis_busy", {31'h0, lsu_busy}, 32'h1);
      tick();
      chk("mis_pulse", {31'h0, lsu_misalign}, 32'h0);
      chk("mis_idle", {31'h0, lsu_busy}, 32'h0);
      chk("mis_no_req2", {31'h0, mem_bus.mem_req}, 32'h0);
`else
      load_fast("lw_mis", 4'b1011, 1'b0, 32'h006, 5'd2, 32'h1122_3344, 32'h4, 4'hF, 32'h1122_3344);
      chk("mis_tied0", {31'h0, lsu_misalign}, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
